// File: rtl/ula_arbitro_pkg.sv
// Shared definitions for the two-requester ALU arbiter: FSM states, opcodes,
// default width and the round-robin grant selection.
package ula_arbitro_pkg;

    localparam int W_PADRAO = 16;

    localparam logic OP_SOMA = 1'b0;
    localparam logic OP_MULT = 1'b1;

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        EXEC   = 2'd1,
        RESP   = 2'd2
    } estado_t;

    // Picks the requester to serve; the pointer only breaks ties.
    function automatic logic escolhe_id(input logic v0, input logic v1, input logic ptr);
        logic id;
        if (v0 && v1) begin
            id = ptr;
        end else if (v1) begin
            id = 1'b1;
        end else begin
            id = 1'b0;
        end
        return id;
    endfunction

endpackage

// File: rtl/ula_arbitro_nucleo.sv
// Combinational unsigned add/multiply core; overflow is the carry-out for add
// and the OR of the discarded upper product half for multiply.
module ula_nucleo
    import ula_arbitro_pkg::*;
#(
    parameter int W = W_PADRAO
) (
    input  logic [W-1:0] e0,
    input  logic [W-1:0] e1,
    input  logic         h,
    output logic [W-1:0] s,
    output logic         ovf
);

    logic [W:0]     w_soma;
    logic [2*W-1:0] w_prod;

    // Both results are always formed; the opcode only selects between them.
    always_comb begin
        w_soma = {1'b0, e0} + {1'b0, e1};
        w_prod = {{W{1'b0}}, e0} * {{W{1'b0}}, e1};
        s      = '0;
        ovf    = 1'b0;
        case (h)
            OP_SOMA: begin
                s   = w_soma[W-1:0];
                ovf = w_soma[W];
            end
            OP_MULT: begin
                s   = w_prod[W-1:0];
                ovf = |w_prod[2*W-1:W];
            end
            default: begin
                s   = '0;
                ovf = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/ula_arbitro.sv
// Round-robin arbiter sharing one ALU core between two requesters, with a
// registered, tagged response channel.
module ula_arbitro
    import ula_arbitro_pkg::*;
#(
    parameter int W = W_PADRAO
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req0_op,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic         req1_op,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [W-1:0] rsp_data,
    output logic         rsp_ovf,
    output logic         busy
);

    estado_t        r_estado;
    logic           r_ptr;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic           r_op;
    logic           r_id;
    logic           r_rsp_valid;
    logic           r_rsp_id;
    logic [W-1:0]   r_rsp_data;
    logic           r_rsp_ovf;
    logic           r_busy;

    logic           w_concede;
    logic           w_id;
    logic           w_pronto;
    logic [W-1:0]   w_sel_a;
    logic [W-1:0]   w_sel_b;
    logic           w_sel_op;
    logic [W-1:0]   w_s;
    logic           w_ovf;

    // Grant decision and operand selection for the requester being accepted.
    always_comb begin
        w_concede = req0_valid | req1_valid;
        w_id      = escolhe_id(req0_valid, req1_valid, r_ptr);
        if (w_id) begin
            w_sel_a  = req1_a;
            w_sel_b  = req1_b;
            w_sel_op = req1_op;
        end else begin
            w_sel_a  = req0_a;
            w_sel_b  = req0_b;
            w_sel_op = req0_op;
        end
    end

    // Ready is suppressed during reset so nothing is accepted on that edge.
    assign w_pronto   = !rst && (r_estado == OCIOSO) && w_concede;
    assign req0_ready = w_pronto && (w_id == 1'b0);
    assign req1_ready = w_pronto && (w_id == 1'b1);

    ula_nucleo #(
        .W (W)
    ) u_nucleo (
        .e0  (r_a),
        .e1  (r_b),
        .h   (r_op),
        .s   (w_s),
        .ovf (w_ovf)
    );

    // Sequencer: accept, execute, then hold the response until consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_estado    <= OCIOSO;
            r_ptr       <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= OP_SOMA;
            r_id        <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_ovf   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_estado)
                OCIOSO: begin
                    if (w_concede) begin
                        r_a      <= w_sel_a;
                        r_b      <= w_sel_b;
                        r_op     <= w_sel_op;
                        r_id     <= w_id;
                        r_busy   <= 1'b1;
                        r_estado <= EXEC;
                    end else begin
                        r_estado <= OCIOSO;
                    end
                end
                EXEC: begin
                    r_rsp_data  <= w_s;
                    r_rsp_ovf   <= w_ovf;
                    r_rsp_id    <= r_id;
                    r_rsp_valid <= 1'b1;
                    r_estado    <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_ptr       <= ~r_rsp_id;
                        r_busy      <= 1'b0;
                        r_estado    <= OCIOSO;
                    end else begin
                        r_estado    <= RESP;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_estado    <= OCIOSO;
                end
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign rsp_ovf   = r_rsp_ovf;
    assign busy      = r_busy;

endmodule

// File: tb/tb_ula_arbitro.sv
// Directed bench for ula_arbitro: handshakes, arithmetic and overflow,
// round-robin alternation, response back-pressure and reset during EXEC.
module tb_ula_arbitro;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         req0_op, req1_op;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_ovf, busy;
    logic [W-1:0] rsp_data;

    int errors = 0;
    int checks = 0;

    ula_arbitro #(.W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_ovf    (rsp_ovf),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Single requester operation, consumer ready as soon as the result appears.
    task automatic run_op(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic op, input logic [W-1:0] exp_d, input logic exp_o);
        if (id) begin
            req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1;
        end else begin
            req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1;
        end
        #1;
        chk("ready_granted", {31'd0, (id ? req1_ready : req0_ready)}, 32'd1);
        chk("ready_other",   {31'd0, (id ? req0_ready : req1_ready)}, 32'd0);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("exec_no_rsp", {31'd0, rsp_valid}, 32'd0);
        chk("exec_busy",   {31'd0, busy}, 32'd1);
        tick();
        chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("rsp_id",    {31'd0, rsp_id}, {31'd0, id});
        chk("rsp_data",  {16'd0, rsp_data}, {16'd0, exp_d});
        chk("rsp_ovf",   {31'd0, rsp_ovf}, {31'd0, exp_o});
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("rsp_done", {31'd0, rsp_valid}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        rsp_ready = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = 16'd0; req0_b = 16'd0; req0_op = 1'b0;
        req1_a = 16'd0; req1_b = 16'd0; req1_op = 1'b0;
        tick();
        tick();
        // Ready must stay low while reset is asserted, even with valids high.
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
        chk("rst_ready1", {31'd0, req1_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_data", {16'd0, rsp_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst = 1'b0;
        tick();
        chk("idle_after_rst", {31'd0, busy}, 32'd0);

        run_op(1'b0, 16'd3, 16'd2, 1'b0, 16'd5, 1'b0);
        run_op(1'b1, 16'd3, 16'd3, 1'b1, 16'd9, 1'b0);
        run_op(1'b0, 16'hFFFF, 16'd1, 1'b0, 16'd0, 1'b1);
        run_op(1'b1, 16'h0100, 16'h0100, 1'b1, 16'd0, 1'b1);
        run_op(1'b0, 16'h00FF, 16'h0101, 1'b1, 16'hFFFF, 1'b0);

        // Consumer ready while idle has no effect.
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("idle_rsp_ready_valid", {31'd0, rsp_valid}, 32'd0);
        chk("idle_rsp_ready_busy", {31'd0, busy}, 32'd0);

        // Fresh reset, then both requesters continuously valid: 0,1,0,1.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req0_a = 16'd1; req0_b = 16'd2; req0_op = 1'b0;
        req1_a = 16'd4; req1_b = 16'd5; req1_op = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            automatic logic exp_id = k[0];
            #1;
            chk("rr_ready0", {31'd0, req0_ready}, {31'd0, ~exp_id});
            chk("rr_ready1", {31'd0, req1_ready}, {31'd0, exp_id});
            tick();
            tick();
            chk("rr_rsp_id", {31'd0, rsp_id}, {31'd0, exp_id});
            chk("rr_rsp_data", {16'd0, rsp_data}, exp_id ? 32'd20 : 32'd3);
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
        end

        // Back-pressure: next grant is req0; hold the response 5 cycles.
        #1;
        chk("bp_ready0", {31'd0, req0_ready}, 32'd1);
        tick();
        tick();
        chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_id", {31'd0, rsp_id}, 32'd0);
            chk("bp_data", {16'd0, rsp_data}, 32'd3);
            chk("bp_ovf", {31'd0, rsp_ovf}, 32'd0);
            chk("bp_ready0", {31'd0, req0_ready}, 32'd0);
            chk("bp_ready1", {31'd0, req1_ready}, 32'd0);
            chk("bp_busy", {31'd0, busy}, 32'd1);
        end
        req0_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("bp_release", {31'd0, rsp_valid}, 32'd0);

        // req1 alone is accepted, then reset hits in EXEC.
        req1_a = 16'd7; req1_b = 16'd8; req1_op = 1'b0;
        #1;
        chk("rx_ready1", {31'd0, req1_ready}, 32'd1);
        tick();
        req1_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rx_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rx_rsp_data", {16'd0, rsp_data}, 32'd0);
        chk("rx_busy", {31'd0, busy}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rx_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        // Pointer is back to 0: req0 wins the tie.
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("rx_ptr_ready0", {31'd0, req0_ready}, 32'd1);
        chk("rx_ptr_ready1", {31'd0, req1_ready}, 32'd0);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        chk("rx_after_id", {31'd0, rsp_id}, 32'd0);
        chk("rx_after_data", {16'd0, rsp_data}, 32'd3);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
